input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Front-end stage for the two-input one-hot control FSM.
- Takes two raw asynchronous inputs, such as buttons or off-chip strobes, and makes them clean for the FSM:
  - synchronises each one into clk,
  - debounces each one with a stability counter,
  - drives `input_sig_1` / `input_sig_2` as either a one-cycle rising-edge pulse or a debounced level.
- The FSM consumes these outputs directly, with no further qualification.

Parameters:
- SYNC_STAGES, 2: flops in each synchroniser chain; legal range is 2 or more.
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronised input must differ from the stable value before the stable value flips; legal range is 1 or more.
- PULSE_MODE, 1: 1 = outputs are one-cycle pulses on a debounced rise; 0 = outputs follow the debounced level.
- GLITCH_CNT_W, 8: width of each glitch counter (optional feature).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- en  in  1  conditioning enable.
- raw_sig_1  in  1  asynchronous raw input, channel 1.
- raw_sig_2  in  1  asynchronous raw input, channel 2.
- input_sig_1  out  1  conditioned channel 1 (pulse or level per PULSE_MODE); feeds the FSM.
- input_sig_2  out  1  conditioned channel 2; feeds the FSM.
- lvl_1  out  1  debounced stable level, channel 1 (always level).
- lvl_2  out  1  debounced stable level, channel 2.
- glitch_cnt_1  out  GLITCH_CNT_W  rejected-bounce count, channel 1.
- glitch_cnt_2  out  GLITCH_CNT_W  rejected-bounce count, channel 2.

Behaviour:
- Reset (rst=0, asynchronous): all of the following go to 0 immediately and hold while rst=0:
  - synchroniser flops, debounce counters, stable levels,
  - input_sig_*, lvl_*, glitch_cnt_*.
- Channels are fully independent. Both may assert input_sig_* in the same cycle; no priority between them.
- Synchroniser: a chain of SYNC_STAGES flops per channel. It always runs, regardless of en. Call its last stage s.
- Per-channel debounce, with stable register st and counter cnt (width clog2(DEBOUNCE_CYCLES+1)):
  - en=0: cnt<=0, st holds, input_sig_* <=0 in pulse mode; the glitch counter does not increment.
  - en=1, s==st: cnt<=0.
  - en=1, s!=st, cnt==DEBOUNCE_CYCLES-1: st<=s, cnt<=0.
  - en=1, s!=st, otherwise: cnt<=cnt+1.
- Latency: raw held high from before edge 0 with en=1 gives st=1 after exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges. Defaults give 6.
- Pulse mode: input_sig_* is registered and asserted for exactly one cycle, on the same edge st goes 0->1. A 1->0 transition produces no pulse. A held-high input produces one pulse only.
- Level mode: input_sig_* = st.
- lvl_* = st in both modes.
- Bounce: if s returns to st while cnt!=0, the attempt is abandoned (cnt<=0) and st is unchanged.
- DEBOUNCE_CYCLES=1: st follows s with one edge delay; the block acts as a pure synchroniser plus edge detector.
- en deasserted mid-count: the count is discarded. The next count restarts from 0 after en=1.
- Reset mid-count or mid-pulse: the pulse is truncated and the count is lost. No pulse is generated on reset release, even if raw is already high; it appears after the full latency from release.

Optional Feature:
- Macro: INPUT_COND_GLITCH_CNT_EN.
- Defined:
  - Each channel keeps a saturating GLITCH_CNT_W counter.
  - It increments by 1 on every abandoned attempt (en=1, s==st, cnt!=0).
  - It holds at all-ones once saturated and clears only on reset.
- Undefined: glitch_cnt_* ports remain present but are tied to 0; no counter logic is generated.

Decomposition:
- Package input_cond_pkg:
  - default constants for SYNC_STAGES, DEBOUNCE_CYCLES and GLITCH_CNT_W,
  - PULSE_MODE encoding constants (MODE_LEVEL=0, MODE_PULSE=1),
  - a count-width function clog2(DEBOUNCE_CYCLES+1).
- Sub-module input_cond_chan:
  - one channel: synchroniser, debounce counter, st, edge/pulse register, optional glitch counter;
  - instantiated twice by input_conditioner.

Test Plan:
1. Defaults, en=1. Raw_sig_1 rises and is held for 20 cycles -> input_sig_1 is high for exactly 1 cycle, 6 edges after the rise; lvl_1 stays 1; input_sig_2 stays 0.
2. Raw_sig_2 high for 2 cycles, low for 1, then high -> no pulse at the 6-edge mark. The pulse appears 6 edges after the final rise. With INPUT_COND_GLITCH_CNT_EN, glitch_cnt_2 = 1.
3. Both raw inputs rise on the same cycle -> input_sig_1 and input_sig_2 pulse on the same cycle, 6 edges later.
4. Raw_sig_1 high; en dropped to 0 at edge 4; en=1 again at edge 10 -> lvl_1 still 0 at edge 10; pulse 4 edges after en returns (sync already settled), i.e. at edge 14.
5. rst=0 asserted asynchronously mid-pulse -> input_sig_1, lvl_1 and glitch_cnt_1 drop to 0 immediately. After release with raw held high, the pulse appears 6 edges after release.
6. PULSE_MODE=0, DEBOUNCE_CYCLES=1. Raw_sig_1 high 5 cycles, then low -> input_sig_1 high for 5 cycles starting 3 edges after the rise, and low 3 edges after the fall.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the input conditioner.
// Default widths, output-mode encodings and the debounce counter width.
package input_cond_pkg;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_GLITCH_CNT_W    = 8;

  localparam int unsigned MODE_LEVEL = 0;
  localparam int unsigned MODE_PULSE = 1;

  // Bits needed to hold 0..debounce_cycles.
  function automatic int unsigned cnt_width(input int unsigned debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/input_cond_chan.sv
// One conditioning channel: synchroniser, debounce counter, rising-edge pulse.
// Optional saturating glitch counter when INPUT_COND_GLITCH_CNT_EN is defined.
module input_cond_chan
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_MODE      = MODE_PULSE,
  parameter int unsigned GLITCH_CNT_W    = DEF_GLITCH_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_raw,
  output logic                    o_sig,
  output logic                    o_lvl,
  output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
);

  localparam int unsigned        CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_st;
  logic                   w_st_nxt;
  logic                   r_pulse;
  logic                   w_pulse_nxt;
  logic                   w_s;

  // Synchroniser runs independently of the enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Stable value flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    w_cnt_nxt   = '0;
    w_st_nxt    = r_st;
    w_pulse_nxt = 1'b0;
    if (i_en && (w_s != r_st)) begin
      if (r_cnt == CNT_LAST) begin
        w_st_nxt    = w_s;
        w_pulse_nxt = w_s;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_st    <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_st    <= w_st_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign o_lvl = r_st;
  assign o_sig = (PULSE_MODE == MODE_PULSE) ? r_pulse : r_st;

`ifdef INPUT_COND_GLITCH_CNT_EN
  logic                    w_abandon;
  logic [GLITCH_CNT_W-1:0] r_glitch;

  // An attempt is abandoned when the input falls back before the count completes.
  assign w_abandon = i_en && (w_s == r_st) && (r_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_glitch <= '0;
    end else if (w_abandon && (r_glitch != '1)) begin
      r_glitch <= r_glitch + GLITCH_CNT_W'(1);
    end
  end

  assign o_glitch_cnt = r_glitch;
`else
  assign o_glitch_cnt = '0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Two independent conditioned inputs feeding the one-hot control FSM.
// Define INPUT_COND_GLITCH_CNT_EN to enable the per-channel glitch counters.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_MODE      = MODE_PULSE,
  parameter int unsigned GLITCH_CNT_W    = DEF_GLITCH_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    raw_sig_1,
  input  logic                    raw_sig_2,
  output logic                    input_sig_1,
  output logic                    input_sig_2,
  output logic                    lvl_1,
  output logic                    lvl_2,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_1,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_2
);

  input_cond_chan #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .PULSE_MODE      (PULSE_MODE),
    .GLITCH_CNT_W    (GLITCH_CNT_W)
  ) u_chan_1 (
    .clk          (clk),
    .rst          (rst),
    .i_en         (en),
    .i_raw        (raw_sig_1),
    .o_sig        (input_sig_1),
    .o_lvl        (lvl_1),
    .o_glitch_cnt (glitch_cnt_1)
  );

  input_cond_chan #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .PULSE_MODE      (PULSE_MODE),
    .GLITCH_CNT_W    (GLITCH_CNT_W)
  ) u_chan_2 (
    .clk          (clk),
    .rst          (rst),
    .i_en         (en),
    .i_raw        (raw_sig_2),
    .o_sig        (input_sig_2),
    .o_lvl        (lvl_2),
    .o_glitch_cnt (glitch_cnt_2)
  );

endmodule
